// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_bank divider bank.
package clk_div_pkg;

    localparam int DEF_CNT_W = 8;

    typedef logic [DEF_CNT_W-1:0] div_t;

    localparam div_t DIV_DISABLE = '0;

    // A divisor of 1 cannot produce a toggling output, so it runs as /2.
    function automatic div_t norm_div(input div_t d);
        return (d == div_t'(1)) ? div_t'(2) : d;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadow divisor, apply-at-wrap logic and
// registered outputs. The tick output exists only when CLK_DIV_TICK_EN
// is defined.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RESET_DIV = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_pend,
    output logic             o_div_out
`ifdef CLK_DIV_TICK_EN
    , output logic           o_tick
`endif
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_dact;
    logic [CNT_W-1:0] r_dpend;
    logic             r_pend;
    logic             r_out;

    logic [CNT_W-1:0] w_div_norm;
    logic [CNT_W-1:0] w_half;
    logic             w_dis;
    logic             w_wrap;
    logic             w_acc;

    generate
        if (CNT_W == DEF_CNT_W) begin : g_pkg_norm
            assign w_div_norm = norm_div(i_div);
        end else begin : g_local_norm
            assign w_div_norm = (i_div == CNT_W'(1)) ? CNT_W'(2) : i_div;
        end
    endgenerate

    assign w_dis  = (r_dact == CNT_W'(DIV_DISABLE));
    assign w_half = r_dact >> 1;
    // d_act is never 1, so any non-zero divisor here is at least 2.
    assign w_wrap = !w_dis && (r_cnt == (r_dact - CNT_W'(1)));
    assign w_acc  = i_wr && !r_pend;

    // Counter, active divisor, pending flag and divided output.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_dact <= CNT_W'(RESET_DIV);
            r_pend <= 1'b0;
            r_out  <= 1'b0;
        end else if (i_sync) begin
            r_cnt <= '0;
            r_out <= 1'b0;
            if (r_pend)
                r_dact <= r_dpend;
            // Clears a pending divisor just applied, or holds a write
            // accepted on this same edge (only possible when none pending).
            r_pend <= w_acc;
        end else begin
            if (w_dis) begin
                r_cnt <= '0;
                r_out <= 1'b0;
            end else begin
                r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
                r_out <= (r_cnt < w_half);
            end
            if (r_pend && (w_wrap || w_dis)) begin
                r_dact <= r_dpend;
                r_pend <= 1'b0;
                r_cnt  <= '0;
            end else if (w_acc) begin
                r_pend <= 1'b1;
            end
        end
    end

    // Shadow divisor is pure data, captured only on an accepted write.
    always_ff @(posedge i_clk) begin
        if (w_acc)
            r_dpend <= w_div_norm;
    end

`ifdef CLK_DIV_TICK_EN
    logic r_tick;

    // One-cycle pulse marking the start of each output period.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_tick <= 1'b0;
        else if (i_sync)
            r_tick <= 1'b0;
        else
            r_tick <= w_wrap;
    end

    assign o_tick = r_tick;
`endif

    assign o_pend    = r_pend;
    assign o_div_out = r_out;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH runtime-programmable integer clock dividers with
// glitch-free divisor updates and a global phase-restart input.
// Define CLK_DIV_TICK_EN to add the per-channel tick outputs.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RESET_DIV = 2,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] div_out
`ifdef CLK_DIV_TICK_EN
    , output logic [NUM_CH-1:0] tick
`endif
);

    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_wr;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
            assign w_wr[i] = cfg_valid && (cfg_ch == CH_W'(i));

            clk_div_chan #(
                .CNT_W     (CNT_W),
                .RESET_DIV (RESET_DIV)
            ) u_chan (
                .i_clk     (clk),
                .i_reset   (reset),
                .i_sync    (sync),
                .i_wr      (w_wr[i]),
                .i_div     (cfg_div),
                .o_pend    (w_pend[i]),
                .o_div_out (div_out[i])
`ifdef CLK_DIV_TICK_EN
                , .o_tick  (tick[i])
`endif
            );
        end
    endgenerate

    // Ready reflects the addressed channel's pending flag; an address
    // beyond NUM_CH is never ready.
    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i))
                cfg_ready = !w_pend[i];
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank (NUM_CH=4, CNT_W=8, RESET_DIV=2).
module tb_clk_div_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sync = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_ready;
    logic [3:0] div_out;
`ifdef CLK_DIV_TICK_EN
    logic [3:0] tick;
`endif

    int n_chk = 0;
    int n_err = 0;

    clk_div_bank #(
        .NUM_CH    (4),
        .CNT_W     (8),
        .RESET_DIV (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .div_out   (div_out)
`ifdef CLK_DIV_TICK_EN
        , .tick    (tick)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [1:0] ch;
        logic [7:0] dv;
        logic       rdy;
        logic [3:0] out;
        logic [3:0] tk;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg(input logic v, input logic [1:0] c, input logic [7:0] d);
        cfg_valid = v;
        cfg_ch    = c;
        cfg_div   = d;
    endtask

    initial begin
        logic [3:0] exp_rst [4];
        logic       exp_d   [6];
        logic [3:0] exp_s   [4];

        // vld, ch, div, ready before edge, div_out after edge, tick after edge
        vecs[0]  = '{1'b0, 2'd0, 8'd0, 1'b1, 4'b1111, 4'b0000};
        vecs[1]  = '{1'b0, 2'd0, 8'd0, 1'b1, 4'b0000, 4'b1111};
        vecs[2]  = '{1'b0, 2'd0, 8'd0, 1'b1, 4'b1111, 4'b0000};
        vecs[3]  = '{1'b0, 2'd0, 8'd0, 1'b1, 4'b0000, 4'b1111};
        vecs[4]  = '{1'b1, 2'd1, 8'd6, 1'b1, 4'b1111, 4'b0000};
        vecs[5]  = '{1'b1, 2'd1, 8'd9, 1'b0, 4'b0000, 4'b1111};
        vecs[6]  = '{1'b0, 2'd1, 8'd0, 1'b1, 4'b1111, 4'b0000};
        vecs[7]  = '{1'b0, 2'd1, 8'd0, 1'b1, 4'b0010, 4'b1101};
        vecs[8]  = '{1'b0, 2'd1, 8'd0, 1'b1, 4'b1111, 4'b0000};
        vecs[9]  = '{1'b0, 2'd1, 8'd0, 1'b1, 4'b0000, 4'b1101};
        vecs[10] = '{1'b0, 2'd1, 8'd0, 1'b1, 4'b1101, 4'b0000};
        vecs[11] = '{1'b0, 2'd1, 8'd0, 1'b1, 4'b0000, 4'b1111};
        vecs[12] = '{1'b1, 2'd2, 8'd5, 1'b1, 4'b1111, 4'b0000};
        vecs[13] = '{1'b0, 2'd2, 8'd0, 1'b0, 4'b0010, 4'b1101};
        vecs[14] = '{1'b0, 2'd2, 8'd0, 1'b1, 4'b1111, 4'b0000};
        vecs[15] = '{1'b0, 2'd2, 8'd0, 1'b1, 4'b0100, 4'b1001};
        vecs[16] = '{1'b0, 2'd2, 8'd0, 1'b1, 4'b1001, 4'b0000};
        vecs[17] = '{1'b0, 2'd2, 8'd0, 1'b1, 4'b0000, 4'b1011};
        vecs[18] = '{1'b0, 2'd2, 8'd0, 1'b1, 4'b1011, 4'b0100};
        vecs[19] = '{1'b0, 2'd2, 8'd0, 1'b1, 4'b0110, 4'b1001};
        vecs[20] = '{1'b0, 2'd2, 8'd0, 1'b1, 4'b1111, 4'b0000};
        vecs[21] = '{1'b0, 2'd2, 8'd0, 1'b1, 4'b0000, 4'b1001};
        vecs[22] = '{1'b0, 2'd2, 8'd0, 1'b1, 4'b1001, 4'b0000};
        vecs[23] = '{1'b0, 2'd2, 8'd0, 1'b1, 4'b0000, 4'b1111};

        exp_rst = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};
        exp_d   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_s   = '{4'b1111, 4'b1110, 4'b0011, 4'b0001};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_div_out", div_out, 4'b0000);
        chk("reset_ready", cfg_ready, 1'b1);
`ifdef CLK_DIV_TICK_EN
        chk("reset_tick", tick, 4'b0000);
`endif
        reset = 1'b0;

        // Table: /2 startup, ch1 -> /6, ch2 -> /5
        for (int i = 0; i < 24; i++) begin
            cfg(vecs[i].vld, vecs[i].ch, vecs[i].dv);
            #1;
            chk($sformatf("row%0d_ready", i), cfg_ready, vecs[i].rdy);
            step();
            chk($sformatf("row%0d_div_out", i), div_out, vecs[i].out);
`ifdef CLK_DIV_TICK_EN
            chk($sformatf("row%0d_tick", i), tick, vecs[i].tk);
`endif
        end

        // Divisor 1 runs as /2 (ch2 currently /5 at cnt 0)
        cfg(1'b1, 2'd2, 8'd1);
        step();
        cfg(1'b0, 2'd2, 8'd0);
        #1;
        chk("div1_pending_ready", cfg_ready, 1'b0);
        repeat (4) step();
        chk("div1_applied_ready", cfg_ready, 1'b1);
        chk("div1_apply_edge_out", div_out[2], 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("div1_e%0d", k), div_out[2], (k % 2 == 0));
        end

        // Write landing on a wrap edge stays pending; then async reset
        cfg(1'b1, 2'd3, 8'd8);
        step();
        cfg(1'b0, 2'd3, 8'd0);
        #1;
        chk("wrap_edge_write_pending", cfg_ready, 1'b0);
        step();
        chk("pre_reset_ch3_high", div_out[3], 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_out", div_out, 4'b0000);
        chk("async_reset_ready", cfg_ready, 1'b1);
        @(negedge clk);
        chk("reset_hold_out", div_out, 4'b0000);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("post_reset_e%0d", k), div_out, exp_rst[k]);
        end

        // Disable ch0, then re-enable at /4 from the disabled state
        cfg(1'b1, 2'd0, 8'd0);
        step();
        chk("dis_d1", div_out[0], 1'b1);
        cfg(1'b0, 2'd0, 8'd0);
        step();
        chk("dis_d2", div_out[0], 1'b0);
        step();
        chk("dis_ready", cfg_ready, 1'b1);
        chk("dis_d3", div_out[0], 1'b0);
        step();
        step();
        chk("dis_d5", div_out[0], 1'b0);
        cfg(1'b1, 2'd0, 8'd4);
        #1;
        chk("dis_write_ready", cfg_ready, 1'b1);
        step();
        cfg(1'b0, 2'd0, 8'd0);
        #1;
        chk("dis_pending_ready", cfg_ready, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("reen_d%0d", k + 7), div_out[0], exp_d[k]);
        end

        // Sync with channels at /6 and /4 mid-period and one pending divisor
        reset = 1'b1;
        #1;
        reset = 1'b0;
        cfg(1'b1, 2'd1, 8'd6);
        step();
        cfg(1'b0, 2'd1, 8'd0);
        step();
        cfg(1'b1, 2'd2, 8'd4);
        step();
        cfg(1'b0, 2'd2, 8'd0);
        step();
        cfg(1'b1, 2'd3, 8'd4);
        step();
        cfg(1'b1, 2'd0, 8'd6);
        sync = 1'b1;
        step();
        sync = 1'b0;
        cfg(1'b0, 2'd0, 8'd0);
        chk("sync_div_out", div_out, 4'b0000);
`ifdef CLK_DIV_TICK_EN
        chk("sync_tick", tick, 4'b0000);
`endif
        #1;
        chk("sync_same_cycle_write_pending", cfg_ready, 1'b0);
        cfg_ch = 2'd3;
        #1;
        chk("sync_applied_pending_ready", cfg_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("post_sync_e%0d", k), div_out, exp_s[k]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Bank of `NUM_CH` independent, runtime-programmable integer clock dividers sharing one clock. It generalises the fixed /2, /4 and /6 divider to any divisor from 2 to 2^`CNT_W`−1 per channel. Divisor changes are glitch-free: a new divisor takes effect only at the end of the current output period. A global `sync` input phase-aligns all channels. The block sits in the clocking/timebase area and feeds enables and slow strobes to downstream logic.

## Interface
- `NUM_CH`, 4: number of divider channels (≥1).
- `CNT_W`, 8: counter and divisor width. Maximum divisor is 2^`CNT_W`−1.
- `RESET_DIV`, 2: active divisor of every channel after reset. Must be ≥2.
- `clk` input 1: the single clock.
- `reset` input 1: asynchronous, active-high reset.
- `sync` input 1: synchronous phase restart for all channels.
- `cfg_valid` input 1: divisor write request.
- `cfg_ready` output 1: write accepted when high together with `cfg_valid`.
- `cfg_ch` input $clog2(`NUM_CH`) (min 1): target channel.
- `cfg_div` input `CNT_W`: new divisor. 0 means disable; 1 is treated as 2.
- `div_out` output `NUM_CH`: divided clock outputs, registered.
- `tick` output `NUM_CH`: one-cycle period pulse per channel. Present only with `CLK_DIV_TICK_EN`.

## Operation
- Per-channel state:
  - `cnt` (`CNT_W` bits).
  - `d_act`, the active divisor.
  - `d_pend`, the shadow divisor.
  - `pend`, a flag marking a shadow divisor waiting to be applied.
- Reset values: `cnt`=0, `d_act`=`RESET_DIV`, `pend`=0, `div_out`=0, `tick`=0.
- Counting, when `d_act`≥2:
  - `cnt` runs 0..`d_act`−1 and then wraps to 0.
  - Each edge, `div_out` <= (`cnt` < `d_act`>>1), evaluated on the pre-edge `cnt`.
  - Result: high for floor(D/2) cycles and low for ceil(D/2) cycles. The output lags `cnt` by one cycle.
- Disabled, when `d_act`=0: `cnt` is held at 0 and `div_out` is held at 0.
- Config handshake:
  - `cfg_ready` = !`pend`[`cfg_ch`], so it is combinational on `cfg_ch`.
  - On acceptance, `d_pend` <= `cfg_div`, with 1 mapped to 2, and `pend` <= 1.
  - Writes to a channel whose `pend` is set stall until the pending divisor is applied.
- Apply rule:
  - When `pend`=1 and (`cnt`=`d_act`−1, or `d_act`=0), then on that edge `d_act` <= `d_pend`, `pend` <= 0 and `cnt` <= 0.
  - A write accepted on the same edge as a wrap is not applied at that wrap. It waits for the next wrap.
- `sync`=1 on an edge:
  - Every channel: `cnt` <= 0, `div_out` <= 0, `tick` <= 0.
  - Any pending divisor is applied immediately and its `pend` is cleared.
  - `sync` has priority over counting and over a same-cycle cfg acceptance. That write is accepted and stays pending.
- Reset mid-operation clears all state immediately, asynchronously. Pending writes are lost.

## Timing
- Divisor write latency: from acceptance to the new period start is at most the remaining cycles of the current period plus 1 edge.
- A disabled channel applies its pending divisor on the edge after acceptance.
- `tick`[i] <= (`cnt`=`d_act`−1 and `d_act`≥2). It is high in the cycle where `cnt` reads 0, once per period.
- There are no combinational paths from inputs to `div_out` or `tick`.

## Configuration
- `CLK_DIV_TICK_EN` defined: the `tick` port and its registers exist.
- `CLK_DIV_TICK_EN` undefined: the `tick` port is absent. All other behaviour is identical.

## Structure
- Package `clk_div_pkg`:
  - Default `CNT_W`.
  - Typedef `div_t` of `CNT_W` bits.
  - Constant `DIV_DISABLE`=0.
  - Function `norm_div()`, which performs the 1→2 mapping.
- Sub-module `clk_div_chan`: one channel's counter, shadow register, apply logic and output registers. The top instantiates `NUM_CH` of them and muxes `cfg_ready`.

## Test plan
- Reset, `RESET_DIV`=2: after `reset` falls, `div_out`[0] = 1,0,1,0… from the first edge, and `tick` pulses every 2 cycles.
- Running at /2, write ch1 `cfg_div`=6: the old period completes, then `div_out`[1] is high 3 and low 3 repeating. `cfg_ready` for ch1 is low until the apply edge.
- Write ch2 `cfg_div`=5: `div_out`[2] is high 2 and low 3, and `tick`[2] pulses every 5 cycles. Write `cfg_div`=1: behaves as /2.
- Write ch0 `cfg_div`=0: after the wrap, `div_out`[0] stays 0. Then write 4: applied on the next edge, giving high 2, low 2.
- Channels at /4 and /6 mid-period, pulse `sync`: all `cnt`=0 and outputs 0 on the next cycle, then rising edges aligned. A same-cycle pending divisor is used immediately.
- Assert `reset` asynchronously mid-period with a write pending: outputs drop to 0 without a clock edge, the pending write is discarded, and channels resume at `RESET_DIV`.
